// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT stepping of a shared datapath.
// Latency: 3..5 cycles per instruction plus MEM_WAIT per memory access; strobes decode combinationally from state.
// Backpressure: none; memory wait is a fixed MEM_WAIT stretch counted by an internal wait counter.
module mc_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       addr_misaligned,
  output logic       imem_re,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       dmem_re,
  output logic       dmem_we,
  output logic       rf_we,
  output logic [1:0] rd_sel,
  output logic       halt,
  output logic [2:0] state
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;

  logic cnt_last;
  logic is_load, is_store, is_branch, is_jal, is_jalr;
  logic legal;
  logic exec_fault;

  assign cnt_last  = (cnt_q == CNT_LAST);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  // A not-taken branch never uses its target, so its alignment is irrelevant.
  assign exec_fault = addr_misaligned &
                      (is_load | is_store | is_jal | is_jalr | (is_branch & branch_taken));

  // Legal-instruction check applied in DECODE.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_OPIMM, OP_OP: legal = 1'b1;
      OP_JALR:   legal = (funct3 == 3'd0);
      OP_BRANCH: legal = (funct3 != 3'd2) && (funct3 != 3'd3);
      OP_LOAD:   legal = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      OP_STORE:  legal = (funct3 <= 3'd2);
      default:   legal = 1'b0;
    endcase
  end

  // Sequencer state and memory wait counter; counter clears on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (cnt_last) begin
            state_q <= S_DECODE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DECODE: begin
          state_q <= legal ? S_EXEC : S_HALT;
          cnt_q   <= '0;
        end
        S_EXEC: begin
          cnt_q <= '0;
          if (exec_fault)                 state_q <= S_HALT;
          else if (is_branch)             state_q <= S_FETCH;
          else if (is_load || is_store)   state_q <= S_MEM;
          else                            state_q <= S_WB;
        end
        S_MEM: begin
          if (cnt_last) begin
            state_q <= is_load ? S_WB : S_FETCH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= S_HALT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Datapath strobes; reset forces every strobe low regardless of the held state.
  always_comb begin
    imem_re = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 2'd0;
    dmem_re = 1'b0;
    dmem_we = 1'b0;
    rf_we   = 1'b0;
    rd_sel  = 2'd0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_re = 1'b1;
          ir_we   = cnt_last;
        end
        S_EXEC: begin
          if (is_branch && !exec_fault) begin
            pc_we  = 1'b1;
            pc_sel = branch_taken ? 2'd1 : 2'd0;
          end
        end
        S_MEM: begin
          if (is_load) begin
            dmem_re = 1'b1;
          end else if (is_store) begin
            dmem_we = 1'b1;
            pc_we   = cnt_last;
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          rd_sel = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
          pc_we  = 1'b1;
          pc_sel = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        end
        default: ;
      endcase
    end
  end

  assign halt  = (state_q == S_HALT);
  assign state = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
module tb_mc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       addr_misaligned;

  logic       imem_re0, ir_we0, pc_we0, dmem_re0, dmem_we0, rf_we0, halt0;
  logic [1:0] pc_sel0, rd_sel0;
  logic [2:0] state0;
  logic       imem_re1, ir_we1, pc_we1, dmem_re1, dmem_we1, rf_we1, halt1;
  logic [1:0] pc_sel1, rd_sel1;
  logic [2:0] state1;

  always #5 clk = ~clk;

  mc_sequencer #(.MEM_WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .addr_misaligned(addr_misaligned),
    .imem_re(imem_re0), .ir_we(ir_we0), .pc_we(pc_we0), .pc_sel(pc_sel0),
    .dmem_re(dmem_re0), .dmem_we(dmem_we0), .rf_we(rf_we0), .rd_sel(rd_sel0),
    .halt(halt0), .state(state0)
  );

  mc_sequencer #(.MEM_WAIT(2)) u_dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .addr_misaligned(addr_misaligned),
    .imem_re(imem_re1), .ir_we(ir_we1), .pc_we(pc_we1), .pc_sel(pc_sel1),
    .dmem_re(dmem_re1), .dmem_we(dmem_we1), .rf_we(rf_we1), .rd_sel(rd_sel1),
    .halt(halt1), .state(state1)
  );

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b0000000;

  // Packed output layout: {state[2:0], imem_re, ir_we, pc_we, pc_sel[1:0], dmem_re, dmem_we, rf_we, rd_sel[1:0], halt}
  typedef struct {
    bit          dut;
    bit          chk;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        bt;
    logic        am;
    logic [13:0] exp;
    string       tag;
  } vec_t;

  vec_t  vq[$];
  string cur;
  int    n_vec  = 0;
  int    n_fail = 0;

  function automatic logic [13:0] o(input logic [2:0] st, input logic imem, input logic ir,
                                    input logic pcwe, input logic [1:0] pcsel, input logic dre,
                                    input logic dwe, input logic rfwe, input logic [1:0] rdsel,
                                    input logic hlt);
    return {st, imem, ir, pcwe, pcsel, dre, dwe, rfwe, rdsel, hlt};
  endfunction

  task automatic v(input bit d, input logic r, input logic [6:0] op, input logic [2:0] f3,
                   input logic bt, input logic am, input bit chk, input logic [13:0] e);
    vec_t x;
    x.dut = d; x.chk = chk; x.rst = r; x.op = op; x.f3 = f3;
    x.bt = bt; x.am = am; x.exp = e; x.tag = cur;
    vq.push_back(x);
  endtask

  logic [13:0] got;
  logic [13:0] FI, FN, DE, EX, HA, M3;

  initial begin
    rst = 1'b1; opcode = OPI; funct3 = 3'd0; branch_taken = 1'b0; addr_misaligned = 1'b0;

    FI = o(3'd0, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0);
    FN = o(3'd0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0);
    DE = o(3'd1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0);
    EX = o(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0);
    HA = o(3'd5, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1);
    M3 = o(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0);

    // ---------------- MEM_WAIT = 0 instance ----------------
    cur = "reset";     v(0, 1, OPI, 0, 0, 0, 0, FI);
    cur = "addi";      v(0, 0, OPI, 0, 0, 0, 1, FI);
                       v(0, 0, OPI, 0, 0, 0, 1, DE);
                       v(0, 0, OPI, 0, 0, 0, 1, EX);
                       v(0, 0, OPI, 0, 0, 0, 1, o(3'd4, 0, 0, 1, 2'd0, 0, 0, 1, 2'd0, 0));
    cur = "beq_taken"; v(0, 0, BR, 0, 0, 0, 1, FI);
                       v(0, 0, BR, 0, 0, 0, 1, DE);
                       v(0, 0, BR, 0, 1, 0, 1, o(3'd2, 0, 0, 1, 2'd1, 0, 0, 0, 2'd0, 0));
    cur = "beq_nt_mis";v(0, 0, BR, 0, 0, 1, 1, FI);
                       v(0, 0, BR, 0, 0, 1, 1, DE);
                       v(0, 0, BR, 0, 0, 1, 1, o(3'd2, 0, 0, 1, 2'd0, 0, 0, 0, 2'd0, 0));
    cur = "jalr";      v(0, 0, JLR, 0, 0, 0, 1, FI);
                       v(0, 0, JLR, 0, 0, 0, 1, DE);
                       v(0, 0, JLR, 0, 0, 0, 1, EX);
                       v(0, 0, JLR, 0, 0, 0, 1, o(3'd4, 0, 0, 1, 2'd2, 0, 0, 1, 2'd2, 0));
    cur = "jal";       v(0, 0, JL, 0, 0, 0, 1, FI);
                       v(0, 0, JL, 0, 0, 0, 1, DE);
                       v(0, 0, JL, 0, 0, 0, 1, EX);
                       v(0, 0, JL, 0, 0, 0, 1, o(3'd4, 0, 0, 1, 2'd1, 0, 0, 1, 2'd2, 0));
    cur = "lui";       v(0, 0, LUI, 0, 0, 0, 1, FI);
                       v(0, 0, LUI, 0, 0, 0, 1, DE);
                       v(0, 0, LUI, 0, 0, 0, 1, EX);
                       v(0, 0, LUI, 0, 0, 0, 1, o(3'd4, 0, 0, 1, 2'd0, 0, 0, 1, 2'd0, 0));
    cur = "sw";        v(0, 0, ST, 2, 0, 0, 1, FI);
                       v(0, 0, ST, 2, 0, 0, 1, DE);
                       v(0, 0, ST, 2, 0, 0, 1, EX);
                       v(0, 0, ST, 2, 0, 0, 1, o(3'd3, 0, 0, 1, 2'd0, 0, 1, 0, 2'd0, 0));
    cur = "jalr_f3_1"; v(0, 0, JLR, 1, 0, 0, 1, FI);
                       v(0, 0, JLR, 1, 0, 0, 1, DE);
                       v(0, 0, JLR, 1, 0, 0, 1, HA);
    cur = "rst_in_halt"; v(0, 1, JLR, 1, 0, 0, 1, HA);
    cur = "illegal";   v(0, 0, ILL, 0, 0, 0, 1, FI);
                       v(0, 0, ILL, 0, 0, 0, 1, DE);
    // HALT must absorb for 20 cycles whatever the inputs do
    cur = "halt_hold";
    for (int i = 0; i < 20; i++)
      v(0, 0, (i % 3 == 0) ? OPI : ((i % 3 == 1) ? BR : ILL), 3'(i), 1'(i), 1'(i >> 1), 1, HA);
    cur = "rst_exit";  v(0, 1, ST, 2, 0, 0, 1, HA);
                       v(0, 0, ST, 2, 0, 0, 1, FI);
    cur = "sw_mis";    v(0, 0, ST, 2, 0, 1, 1, DE);
                       v(0, 0, ST, 2, 0, 1, 1, EX);
                       v(0, 0, ST, 2, 0, 0, 1, HA);
                       v(0, 0, ST, 2, 0, 0, 1, HA);
    cur = "lw_bad_f3"; v(0, 1, LD, 3, 0, 0, 1, HA);
                       v(0, 0, LD, 3, 0, 0, 1, FI);
                       v(0, 0, LD, 3, 0, 0, 1, DE);
                       v(0, 0, LD, 3, 0, 0, 1, HA);
    cur = "beq_t_mis"; v(0, 1, BR, 0, 1, 1, 1, HA);
                       v(0, 0, BR, 0, 1, 1, 1, FI);
                       v(0, 0, BR, 0, 1, 1, 1, DE);
                       v(0, 0, BR, 0, 1, 1, 1, EX);
                       v(0, 0, BR, 0, 1, 1, 1, HA);

    // ---------------- MEM_WAIT = 2 instance ----------------
    cur = "reset1";    v(1, 1, LD, 2, 0, 0, 0, FN);
    cur = "lw_w2";     v(1, 0, LD, 2, 0, 0, 1, FN);
                       v(1, 0, LD, 2, 0, 0, 1, FN);
                       v(1, 0, LD, 2, 0, 0, 1, FI);
                       v(1, 0, LD, 2, 0, 0, 1, DE);
                       v(1, 0, LD, 2, 0, 0, 1, EX);
    for (int i = 0; i < 3; i++)
                       v(1, 0, LD, 2, 0, 0, 1, o(3'd3, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 0));
                       v(1, 0, LD, 2, 0, 0, 1, o(3'd4, 0, 0, 1, 2'd0, 0, 0, 1, 2'd1, 0));
    cur = "sw_w2";     v(1, 0, ST, 2, 0, 0, 1, FN);
                       v(1, 0, ST, 2, 0, 0, 1, FN);
                       v(1, 0, ST, 2, 0, 0, 1, FI);
                       v(1, 0, ST, 2, 0, 0, 1, DE);
                       v(1, 0, ST, 2, 0, 0, 1, EX);
                       v(1, 0, ST, 2, 0, 0, 1, o(3'd3, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0));
                       v(1, 0, ST, 2, 0, 0, 1, o(3'd3, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0));
                       v(1, 0, ST, 2, 0, 0, 1, o(3'd3, 0, 0, 1, 2'd0, 0, 1, 0, 2'd0, 0));
    cur = "sw_rst_mem";v(1, 0, ST, 2, 0, 0, 1, FN);
                       v(1, 0, ST, 2, 0, 0, 1, FN);
                       v(1, 0, ST, 2, 0, 0, 1, FI);
                       v(1, 0, ST, 2, 0, 0, 1, DE);
                       v(1, 0, ST, 2, 0, 0, 1, EX);
                       v(1, 0, ST, 2, 0, 0, 1, o(3'd3, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0));
                       v(1, 1, ST, 2, 0, 0, 1, M3);
                       v(1, 0, ST, 2, 0, 0, 1, FN);
                       v(1, 0, ST, 2, 0, 0, 1, FN);
                       v(1, 0, ST, 2, 0, 0, 1, FI);

    // Apply one vector per cycle: drive 1ns after the edge, sample 4ns later.
    @(posedge clk); #1;
    for (int k = 0; k < vq.size(); k++) begin
      rst             = vq[k].rst;
      opcode          = vq[k].op;
      funct3          = vq[k].f3;
      branch_taken    = vq[k].bt;
      addr_misaligned = vq[k].am;
      #3;
      if (vq[k].chk) begin
        if (vq[k].dut == 1'b0)
          got = {state0, imem_re0, ir_we0, pc_we0, pc_sel0, dmem_re0, dmem_we0, rf_we0, rd_sel0, halt0};
        else
          got = {state1, imem_re1, ir_we1, pc_we1, pc_sel1, dmem_re1, dmem_we1, rf_we1, rd_sel1, halt1};
        n_vec++;
        if (got !== vq[k].exp) begin
          n_fail++;
          $display("FAIL vec %0d [%s] dut%0d: got st=%0d bits=%b, expected st=%0d bits=%b",
                   k, vq[k].tag, vq[k].dut, got[13:11], got[10:0], vq[k].exp[13:11], vq[k].exp[10:0]);
        end
      end
      @(posedge clk); #1;
    end

    // Reset-state check: held reset gives FETCH, counter 0, no halt, all strobes low.
    rst = 1'b1; opcode = LD; funct3 = 3'd2; branch_taken = 1'b0; addr_misaligned = 1'b0;
    @(posedge clk); #4;
    n_vec++;
    if (state0 !== 3'd0 || halt0 !== 1'b0 || imem_re0 !== 1'b0 || pc_we0 !== 1'b0 || rf_we0 !== 1'b0 ||
        state1 !== 3'd0 || halt1 !== 1'b0 || imem_re1 !== 1'b0 || pc_we1 !== 1'b0 || rf_we1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset-state: st0=%0d h0=%b imem0=%b st1=%0d h1=%b imem1=%b",
               state0, halt0, imem_re0, state1, halt1, imem_re1);
    end

    // Expired-wait check: MEM_WAIT=2 fetch latches IR on its third cycle, then decodes.
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #4;
    n_vec++;
    if (state1 !== 3'd0 || imem_re1 !== 1'b1 || ir_we1 !== 1'b1) begin
      n_fail++;
      $display("FAIL expired-wait: st1=%0d imem_re1=%b ir_we1=%b (expected 0,1,1)",
               state1, imem_re1, ir_we1);
    end
    @(posedge clk); #4;
    n_vec++;
    if (state1 !== 3'd1 || imem_re1 !== 1'b0 || ir_we1 !== 1'b0) begin
      n_fail++;
      $display("FAIL post-wait decode: st1=%0d imem_re1=%b ir_we1=%b (expected 1,0,0)",
               state1, imem_re1, ir_we1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
